// File: rtl/powlib_busdist_lane.sv
// Address-decoded fan-out of one bus writer into B_RDS lanes, each with its own FIFO.
// Latency: 2 edges from input acceptance to lane valid (one s0 register stage, one FIFO write).
// Backpressure: wrrdy drops while s0 targets a full lane, which stalls all lanes and keeps global order.
module powlib_busdist_lane #(
  parameter string                  ID      = "BUSDIST",
  parameter int                     EDBG    = 0,
  parameter int                     B_RDS   = 4,
  parameter int                     B_AW    = 2,
  parameter int                     B_DW    = 4,
  parameter logic [B_RDS*B_AW-1:0]  B_BASES = '0,
  parameter logic [B_RDS*B_AW-1:0]  B_SIZES = {B_RDS{B_AW'(1)}},
  parameter int                     D       = 4,
  parameter int                     DCW     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [B_DW-1:0]         wrdata,
  input  logic [B_AW-1:0]         wraddr,
  input  logic                    wrvld,
  output logic                    wrrdy,
  output logic [B_RDS*B_DW-1:0]   rddatas,
  output logic [B_RDS*B_AW-1:0]   rdaddrs,
  output logic [B_RDS-1:0]        rdvlds,
  input  logic [B_RDS-1:0]        rdrdys,
  output logic [DCW-1:0]          dropcnt,
  output logic                    dropped
);

  localparam int PW = $clog2(D);
  localparam int CW = PW + 1;
  localparam int EW = B_AW + B_DW;

  // Elaboration-time parameter sanity; ID tags the message so the failing instance is obvious.
  if (B_RDS < 1 || B_RDS > 16) begin : g_bad_rds
    $error("%s: B_RDS must be in 1..16", ID);
  end
  if (D < 2 || (D & (D - 1)) != 0) begin : g_bad_depth
    $error("%s: D must be a power of 2 and at least 2", ID);
  end
  if (EDBG != 0 && EDBG != 1) begin : g_bad_edbg
    $error("%s: EDBG must be 0 or 1", ID);
  end

  // Stage s0 holds the decoded word waiting to be written into its lane.
  logic [B_DW-1:0]  s0_dat_q,  s0_dat_d;
  logic [B_AW-1:0]  s0_addr_q, s0_addr_d;
  logic [B_RDS-1:0] s0_sel_q,  s0_sel_d;
  logic             s0_miss_q, s0_miss_d;
  logic             s0_vld_q,  s0_vld_d;

  // Per-lane circular buffers; pointers wrap naturally because D is a power of 2.
  logic [EW-1:0]    mem_q  [B_RDS][D];
  logic [EW-1:0]    mem_d  [B_RDS][D];
  logic [PW-1:0]    rptr_q [B_RDS];
  logic [PW-1:0]    rptr_d [B_RDS];
  logic [PW-1:0]    wptr_q [B_RDS];
  logic [PW-1:0]    wptr_d [B_RDS];
  logic [CW-1:0]    cnt_q  [B_RDS];
  logic [CW-1:0]    cnt_d  [B_RDS];

  logic [DCW-1:0]   dropcnt_q, dropcnt_d;
  logic             dropped_q, dropped_d;

  logic [B_RDS-1:0] dec_match;
  logic [B_RDS-1:0] dec_sel;
  logic             dec_miss;
  logic             sel_full;
  logic             s0_drain;
  logic             wr_xfer;
  logic [B_RDS-1:0] push;
  logic [B_RDS-1:0] pop;

  // Range decode on the incoming address; one extra bit so base+size never wraps.
  always_comb begin
    logic [B_AW:0] a;
    logic [B_AW:0] lo;
    logic [B_AW:0] sz;
    a         = {1'b0, wraddr};
    lo        = '0;
    sz        = '0;
    dec_match = '0;
    dec_sel   = '0;
    for (int i = 0; i < B_RDS; i++) begin
      lo           = {1'b0, B_BASES[i*B_AW +: B_AW]};
      sz           = {1'b0, B_SIZES[i*B_AW +: B_AW]};
      dec_match[i] = (sz != '0) && (a >= lo) && (a < lo + sz);
    end
    // Walk from the top so the lowest matching index is the one left standing.
    for (int i = B_RDS - 1; i >= 0; i--) begin
      if (dec_match[i]) begin
        dec_sel    = '0;
        dec_sel[i] = 1'b1;
      end
    end
    dec_miss = (dec_match == '0);
  end

  // s0 drain/accept control; wrrdy depends only on s0 state and lane fill, never on wrvld.
  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < B_RDS; i++) begin
      if (s0_sel_q[i] && cnt_q[i] == CW'(D)) sel_full = 1'b1;
    end
    s0_drain = s0_vld_q && (s0_miss_q || !sel_full);
    wrrdy    = !rst && (!s0_vld_q || s0_drain);
    wr_xfer  = wrvld && wrrdy;
  end

  // s0 next state: load on an input transfer, otherwise empty out once drained.
  always_comb begin
    s0_dat_d  = s0_dat_q;
    s0_addr_d = s0_addr_q;
    s0_sel_d  = s0_sel_q;
    s0_miss_d = s0_miss_q;
    s0_vld_d  = s0_vld_q;
    if (wr_xfer) begin
      s0_dat_d  = wrdata;
      s0_addr_d = wraddr;
      s0_sel_d  = dec_sel;
      s0_miss_d = dec_miss;
      s0_vld_d  = 1'b1;
    end else if (s0_drain) begin
      s0_vld_d  = 1'b0;
    end
  end

  // Lane outputs come straight from each FIFO head.
  always_comb begin
    rddatas = '0;
    rdaddrs = '0;
    rdvlds  = '0;
    for (int i = 0; i < B_RDS; i++) begin
      rdvlds[i] = (cnt_q[i] != '0);
      {rdaddrs[i*B_AW +: B_AW], rddatas[i*B_DW +: B_DW]} = mem_q[i][rptr_q[i]];
    end
  end

  // FIFO push/pop bookkeeping; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    mem_d = mem_q;
    push  = '0;
    pop   = '0;
    for (int i = 0; i < B_RDS; i++) begin
      rptr_d[i] = rptr_q[i];
      wptr_d[i] = wptr_q[i];
      cnt_d[i]  = cnt_q[i];
      push[i]   = s0_drain && !s0_miss_q && s0_sel_q[i];
      pop[i]    = rdvlds[i] && rdrdys[i];
      if (push[i]) begin
        mem_d[i][wptr_q[i]] = {s0_addr_q, s0_dat_q};
        wptr_d[i]           = wptr_q[i] + PW'(1);
      end
      if (pop[i]) begin
        rptr_d[i] = rptr_q[i] + PW'(1);
      end
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Unrouted words are counted (saturating) and latched into a sticky flag as they drain.
  always_comb begin
    dropcnt_d = dropcnt_q;
    dropped_d = dropped_q;
    if (s0_drain && s0_miss_q) begin
      dropped_d = 1'b1;
      if (dropcnt_q != '1) dropcnt_d = dropcnt_q + DCW'(1);
    end
    dropcnt = dropcnt_q;
    dropped = dropped_q;
  end

  // Control state; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_dat_q  <= '0;
      s0_addr_q <= '0;
      s0_sel_q  <= '0;
      s0_miss_q <= 1'b0;
      s0_vld_q  <= 1'b0;
      dropcnt_q <= '0;
      dropped_q <= 1'b0;
      for (int i = 0; i < B_RDS; i++) begin
        rptr_q[i] <= '0;
        wptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      s0_dat_q  <= s0_dat_d;
      s0_addr_q <= s0_addr_d;
      s0_sel_q  <= s0_sel_d;
      s0_miss_q <= s0_miss_d;
      s0_vld_q  <= s0_vld_d;
      dropcnt_q <= dropcnt_d;
      dropped_q <= dropped_d;
      for (int i = 0; i < B_RDS; i++) begin
        rptr_q[i] <= rptr_d[i];
        wptr_q[i] <= wptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  // Payload storage needs no reset: counts gate every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_powlib_busdist_lane.sv
module tb_powlib_busdist_lane;

  logic              clk;
  logic              rst;
  logic [1:0][7:0]   wrdata;
  logic [1:0][3:0]   wraddr;
  logic [1:0]        wrvld;
  logic [1:0]        wrrdy;
  logic [1:0][31:0]  rddatas;
  logic [1:0][15:0]  rdaddrs;
  logic [1:0][3:0]   rdvlds;
  logic [1:0][3:0]   rdrdys;
  logic [1:0][7:0]   dropcnt;
  logic [1:0]        dropped;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q [8][$];
  int exp_drop [2];

  // Instance 0: four disjoint 4-address ranges. Instance 1: overlap, top-of-range and a disabled lane.
  powlib_busdist_lane #(
    .ID("DIST_A"), .EDBG(0), .B_RDS(4), .B_AW(4), .B_DW(8),
    .B_BASES(16'hC840), .B_SIZES(16'h4444), .D(4), .DCW(8)
  ) u_a (
    .clk(clk), .rst(rst), .wrdata(wrdata[0]), .wraddr(wraddr[0]), .wrvld(wrvld[0]), .wrrdy(wrrdy[0]),
    .rddatas(rddatas[0]), .rdaddrs(rdaddrs[0]), .rdvlds(rdvlds[0]), .rdrdys(rdrdys[0]),
    .dropcnt(dropcnt[0]), .dropped(dropped[0])
  );

  powlib_busdist_lane #(
    .ID("DIST_B"), .EDBG(0), .B_RDS(4), .B_AW(4), .B_DW(8),
    .B_BASES(16'hCE20), .B_SIZES(16'h0244), .D(4), .DCW(8)
  ) u_b (
    .clk(clk), .rst(rst), .wrdata(wrdata[1]), .wraddr(wraddr[1]), .wrvld(wrvld[1]), .wrrdy(wrrdy[1]),
    .rddatas(rddatas[1]), .rdaddrs(rdaddrs[1]), .rdvlds(rdvlds[1]), .rdrdys(rdrdys[1]),
    .dropcnt(dropcnt[1]), .dropped(dropped[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference decode: lane index the word must land in, or -1 for a drop.
  function automatic int exp_lane(input int d, input logic [3:0] a);
    int lo [4];
    int sz [4];
    if (d == 0) return int'(a) / 4;
    lo = '{0, 2, 14, 12};
    sz = '{4, 4, 2, 0};
    for (int i = 0; i < 4; i++) begin
      if (sz[i] != 0 && int'(a) >= lo[i] && int'(a) < lo[i] + sz[i]) return i;
    end
    return -1;
  endfunction

  // One clock: scoreboard every lane transfer due at the coming edge, report input acceptance.
  task automatic clk_step(output logic [1:0] acc);
    logic [11:0] got;
    logic [11:0] want;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int l = 0; l < 4; l++) begin
        if (rdvlds[d][l] && rdrdys[d][l]) begin
          got = {rdaddrs[d][l*4 +: 4], rddatas[d][l*8 +: 8]};
          checks++;
          if (exp_q[d*4+l].size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected dut%0d lane%0d got %h expected nothing", d, l, got);
          end else begin
            want = exp_q[d*4+l].pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL sb_word dut%0d lane%0d got %h expected %h", d, l, got, want);
            end
          end
        end
      end
      acc[d] = wrvld[d] && wrrdy[d];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    logic [1:0] acc;
    for (int i = 0; i < n; i++) clk_step(acc);
  endtask

  // Present one word and hold it until accepted or the budget expires; record the expectation.
  task automatic send(input int d, input logic [3:0] a, input logic [7:0] v, input int budget, output bit ok);
    logic [1:0] acc;
    int ln;
    wraddr[d] = a;
    wrdata[d] = v;
    wrvld[d]  = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      clk_step(acc);
      if (acc[d]) ok = 1'b1;
    end
    if (ok) begin
      ln = exp_lane(d, a);
      if (ln < 0) begin
        if (exp_drop[d] < 255) exp_drop[d]++;
      end else begin
        exp_q[d*4+ln].push_back({a, v});
      end
    end
  endtask

  task automatic send_chk(input int d, input logic [3:0] a, input logic [7:0] v);
    bit ok;
    send(d, a, v, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout dut%0d addr %0d accepted %0d expected 1", d, a, ok);
    end
  endtask

  task automatic queues_empty(input string tag);
    for (int q = 0; q < 8; q++) begin
      checks++;
      if (exp_q[q].size() != 0) begin
        errors++;
        $display("FAIL %s_missing dut%0d lane%0d outstanding %0d expected 0", tag, q / 4, q % 4, exp_q[q].size());
      end
    end
  endtask

  task automatic test_reset();
    #3;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (wrrdy[d] !== 1'b0) begin errors++; $display("FAIL rst_wrrdy dut%0d got %b expected 0", d, wrrdy[d]); end
      checks++;
      if (rdvlds[d] !== 4'b0) begin errors++; $display("FAIL rst_rdvlds dut%0d got %b expected 0000", d, rdvlds[d]); end
      checks++;
      if (dropcnt[d] !== 8'd0 || dropped[d] !== 1'b0) begin
        errors++; $display("FAIL rst_drop dut%0d got cnt %0d flag %b expected 0 0", d, dropcnt[d], dropped[d]);
      end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (wrrdy !== 2'b11) begin errors++; $display("FAIL rst_release_wrrdy got %b expected 11", wrrdy); end
  endtask

  task automatic test_routing();
    logic [1:0] acc;
    rdrdys[0] = 4'b1111;
    send_chk(0, 4'd1, 8'h0A);
    wrvld[0] = 1'b0;
    checks++;
    if (rdvlds[0] !== 4'b0000) begin errors++; $display("FAIL lat_early got %b expected 0000", rdvlds[0]); end
    clk_step(acc);
    checks++;
    if (rdvlds[0] !== 4'b0001) begin errors++; $display("FAIL lat_valid got %b expected 0001", rdvlds[0]); end
    send_chk(0, 4'd5,  8'h0B);
    send_chk(0, 4'd9,  8'h0C);
    send_chk(0, 4'd13, 8'h0D);
    wrvld[0] = 1'b0;
    steps(6);
    queues_empty("routing");
    checks++;
    if (dropcnt[0] !== 8'd0) begin errors++; $display("FAIL routing_drop got %0d expected 0", dropcnt[0]); end
  endtask

  task automatic test_miss();
    logic [1:0] acc;
    rdrdys[1] = 4'b1111;
    checks++;
    if (wrrdy[1] !== 1'b1) begin errors++; $display("FAIL miss_wrrdy_pre got %b expected 1", wrrdy[1]); end
    send_chk(1, 4'd13, 8'hEE);
    wrvld[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wrrdy[1] !== 1'b1 || rdvlds[1] !== 4'b0000) begin
        errors++; $display("FAIL miss_idle cycle %0d got wrrdy %b rdvlds %b expected 1 0000", i, wrrdy[1], rdvlds[1]);
      end
      clk_step(acc);
    end
    checks++;
    if (dropcnt[1] !== 8'(exp_drop[1])) begin errors++; $display("FAIL miss_cnt got %0d expected %0d", dropcnt[1], exp_drop[1]); end
    checks++;
    if (dropped[1] !== 1'b1) begin errors++; $display("FAIL miss_flag got %b expected 1", dropped[1]); end
  endtask

  task automatic test_overlap();
    send_chk(1, 4'd3,  8'h31);
    send_chk(1, 4'd15, 8'h3F);
    send_chk(1, 4'd0,  8'h30);
    send_chk(1, 4'd5,  8'h35);
    wrvld[1] = 1'b0;
    steps(6);
    queues_empty("overlap");
    checks++;
    if (dropcnt[1] !== 8'(exp_drop[1])) begin errors++; $display("FAIL overlap_drop got %0d expected %0d", dropcnt[1], exp_drop[1]); end
  endtask

  task automatic test_backpressure();
    bit ok;
    rdrdys[0] = 4'b1110;
    for (int i = 0; i < 5; i++) send_chk(0, 4'(i % 4), 8'(8'h20 + i));
    send(0, 4'd2, 8'h25, 4, ok);
    checks++;
    if (ok !== 1'b0 || wrrdy[0] !== 1'b0) begin
      errors++; $display("FAIL bp_stall got accepted %0d wrrdy %b expected 0 0", ok, wrrdy[0]);
    end
    checks++;
    if (rdvlds[0] !== 4'b0001) begin errors++; $display("FAIL bp_vld got %b expected 0001", rdvlds[0]); end
    rdrdys[0] = 4'b1111;
    send_chk(0, 4'd2, 8'h25);
    wrvld[0] = 1'b0;
    steps(12);
    queues_empty("backpressure");
  endtask

  task automatic test_hol();
    bit ok;
    logic [1:0] acc;
    rdrdys[0] = 4'b1110;
    for (int i = 0; i < 5; i++) send_chk(0, 4'(i % 4), 8'(8'h40 + i));
    send(0, 4'd4, 8'h77, 6, ok);
    checks++;
    if (ok !== 1'b0 || rdvlds[0][1] !== 1'b0) begin
      errors++; $display("FAIL hol_block got accepted %0d lane1 vld %b expected 0 0", ok, rdvlds[0][1]);
    end
    rdrdys[0][0] = 1'b1;
    clk_step(acc);
    rdrdys[0][0] = 1'b0;
    send_chk(0, 4'd4, 8'h77);
    wrvld[0] = 1'b0;
    steps(3);
    rdrdys[0] = 4'b1111;
    steps(10);
    queues_empty("hol");
  endtask

  task automatic test_reset_mid();
    rdrdys[0] = 4'b0000;
    send_chk(0, 4'd0, 8'h50);
    send_chk(0, 4'd4, 8'h51);
    send_chk(0, 4'd8, 8'h52);
    wrvld[0] = 1'b0;
    steps(3);
    checks++;
    if (rdvlds[0] !== 4'b0111) begin errors++; $display("FAIL mid_prefill got %b expected 0111", rdvlds[0]); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rdvlds[0] !== 4'b0000 || wrrdy !== 2'b00) begin
      errors++; $display("FAIL mid_async got rdvlds %b wrrdy %b expected 0000 00", rdvlds[0], wrrdy);
    end
    checks++;
    if (dropcnt[1] !== 8'd0 || dropped[1] !== 1'b0) begin
      errors++; $display("FAIL mid_drop got cnt %0d flag %b expected 0 0", dropcnt[1], dropped[1]);
    end
    for (int q = 0; q < 8; q++) exp_q[q].delete();
    exp_drop[0] = 0;
    exp_drop[1] = 0;
    steps(2);
    rst = 1'b0;
    steps(2);
    checks++;
    if (rdvlds[0] !== 4'b0000 || wrrdy[0] !== 1'b1) begin
      errors++; $display("FAIL mid_after got rdvlds %b wrrdy %b expected 0000 1", rdvlds[0], wrrdy[0]);
    end
    rdrdys[0] = 4'b1111;
    send_chk(0, 4'd6, 8'h5A);
    wrvld[0] = 1'b0;
    steps(5);
    queues_empty("reset_mid");
  endtask

  initial begin
    rst      = 1'b1;
    wrdata   = '0;
    wraddr   = '0;
    wrvld    = '0;
    rdrdys   = '0;
    exp_drop[0] = 0;
    exp_drop[1] = 0;
    test_reset();
    test_routing();
    test_miss();
    test_overlap();
    test_backpressure();
    test_hol();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/powlib_busdist_lane.md
Name: powlib_busdist_lane

Overview:
- Distribution counterpart of the bus crossbar lane: one bus writer fans out to B_RDS reader ports.
- Each accepted word is routed by address range to exactly one output lane, with a per-lane FIFO.
- Words matching no range are dropped and counted.
- Sits between a single bus initiator and several address-decoded responders; order is preserved per lane and globally.

Parameters:
- ID, "BUSDIST", string identifier for debug prints.
- EDBG, 0, enable debug prints (simulation only).
- B_RDS, 4, number of output lanes (1..16).
- B_AW, 2, address width.
- B_DW, 4, data width.
- B_BASES, 0, packed B_RDS*B_AW base addresses; lane i base = B_BASES[i*B_AW+:B_AW].
- B_SIZES, all lanes 1, packed B_RDS*B_AW range sizes; size 0 disables the lane.
- D, 4, per-lane FIFO depth (power of 2, >=2).
- DCW, 8, drop counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- wrdata  in  B_DW  input word data.
- wraddr  in  B_AW  input word address.
- wrvld  in  1  input valid.
- wrrdy  out  1  input ready.
- rddatas  out  B_RDS*B_DW  lane data, lane i at [i*B_DW+:B_DW].
- rdaddrs  out  B_RDS*B_AW  lane address, lane i at [i*B_AW+:B_AW].
- rdvlds  out  B_RDS  per-lane valid.
- rdrdys  in  B_RDS  per-lane ready.
- dropcnt  out  DCW  saturating count of unrouted words.
- dropped  out  1  sticky flag, set on first drop.

Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- Reset values: rdvlds=0, dropcnt=0, dropped=0, stage s0 empty, all FIFO pointers and counts 0. wrrdy=0 while rst is high.
- Handshake:
  - Input transfer occurs when wrvld&&wrrdy at a rising edge.
  - Lane i transfer occurs when rdvlds[i]&&rdrdys[i].
  - rddatas/rdaddrs for lane i hold stable while rdvlds[i]=1 and not transferred.
- Decode, computed on wraddr at acceptance:
  - match[i] = size_i!=0 && addr>=base_i && addr<base_i+size_i.
  - The comparison uses B_AW+1 bits, so base+size never wraps.
  - With multiple matches, the lowest index wins (one-hot select).
  - miss = no match.
- Stage s0 register holds {data, addr, one-hot sel, miss, s0_vld}.
- s0 drain condition:
  - miss=1: always drains.
  - Otherwise drains if count[sel]<D. There is no same-cycle read bypass into a full FIFO.
- wrrdy = !rst && (!s0_vld || s0_drain). This is combinational from s0 state and FIFO counts, never from wrvld.
- Head-of-line blocking: while s0 targets a full lane, wrrdy=0 and all lanes stop receiving new words. This preserves global order.
- Lane FIFO: circular buffer of D entries.
  - Read pointer, write pointer and count each wrap modulo D; count ranges 0..D.
  - Simultaneous push and pop leaves count unchanged.
  - rdvlds[i] = (count[i]!=0).
  - Output data comes from the head entry.
- Latency: a word accepted at edge k is in s0 after k, written to its lane at edge k+1, and its rdvlds bit is high in the cycle after edge k+1. Minimum 2 edges from acceptance to lane read; sustained throughput is 1 word/cycle when no lane is full.
- Drop handling:
  - At the edge where a miss word drains, dropcnt increments, saturating at all-ones, and dropped is set.
  - dropped clears only on reset.
  - With EDBG=1, each drop prints ID, address and time.
- Reset mid-operation: everything returns immediately to reset values. In-flight s0 and FIFO contents are discarded, and no partial word appears afterward.
- Input values are ignored when wrvld=0. s0 loads only on an input transfer; otherwise s0_vld clears on drain.

Test Plan:
- Routing: B_RDS=4, B_AW=4, bases {0,4,8,12}, sizes 4 each. Send addrs 1,5,9,13 with data A,B,C,D, all rdrdys=1. Each lane receives exactly one word; lane 2 gets addr 9/data C. rdvlds rises the cycle after edge k+1. dropcnt=0.
- Miss: lane 3 size 0, send addr 14 → no rdvlds asserted, dropcnt=1, dropped=1; wrrdy stays 1 throughout.
- Backpressure: D=4, rdrdys[0]=0, stream 6 words to lane 0 → 4 stored plus 1 in s0, then wrrdy=0. Raise rdrdys[0] → all 6 words read in order, none lost or duplicated.
- Head-of-line: lane 0 full and s0 holds a lane-0 word, next input targets lane 1 → lane 1 receives nothing until lane 0 pops one entry; order preserved.
- Overlap and boundary: bases {0,2}, sizes {4,4}, addr 3 → lane 0 (lowest index). Base 14, size 2, B_AW=4, addr 15 → match without wrap; addr 0 → no match to that lane.
- Reset mid-stream: assert rst asynchronously with 3 words buffered → rdvlds and wrrdy drop without a clock edge. After release, counts=0, dropcnt=0, and the first new word is delivered correctly.
